adc_multichannel_aligner: RTL and testbench

- Single-clock (alg_clk) aligner for NUM_CH ADC sample streams that have already crossed into the algorithm domain, each with its own enable strobe.
- Buffers each channel in a small per-channel FIFO.
- Emits one lane-aligned word (one sample per channel) only when every channel has data, with out_valid/out_ready backpressure.
- Detects overflow and inter-channel skew, and optionally flushes all channels to re-establish alignment.
- Sits between the CDC stage and the phase-processing algorithm blocks; generalises the fixed A/B two-channel path.

---
 rtl/adc_align_pkg.sv | 19 +
 rtl/adc_multichannel_aligner_sync_fifo_ch.sv | 48 ++++
 rtl/adc_multichannel_aligner.sv | 106 ++++++++++
 tb/tb_adc_multichannel_aligner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_align_pkg.sv
// Shared constants and helpers for the multichannel ADC aligner.
// Lane packing: channel i lives at bits [i*DATA_W +: DATA_W].
package adc_align_pkg;

  localparam int ADC_DATA_W = 16;
  localparam int ADC_NUM_CH = 2;

  function automatic int clog2_c(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int lane_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/adc_multichannel_aligner_sync_fifo_ch.sv
// Per-channel sample FIFO with first-word-fall-through read data.
// The caller guarantees wr_en only when not full or rd_en also set.
module sync_fifo_ch
  import adc_align_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int DEPTH  = 16,
  parameter int LW     = clog2_c(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  localparam int AW = clog2_c(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/adc_multichannel_aligner.sv
// Aligns NUM_CH ADC streams into one word per pop with backpressure,
// sticky overflow/skew status and optional automatic resync flush.
module adc_multichannel_aligner
  import adc_align_pkg::*;
#(
  parameter int NUM_CH     = ADC_NUM_CH,
  parameter int DATA_W     = ADC_DATA_W,
  parameter int DEPTH      = 16,
  parameter int SKEW_LIMIT = 8,
  parameter int CNT_W      = 32
) (
  input  logic                     alg_clk,
  input  logic                     alg_rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     resync_en,
  input  logic                     clear_status,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     skew_err,
  output logic [CNT_W-1:0]         word_count
);

  localparam int LW = clog2_c(DEPTH) + 1;

  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        empty;
  logic [LW-1:0]            level [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] rd_word;
  logic [NUM_CH-1:0]        wr_acc;
  logic [NUM_CH-1:0]        drop;
  logic                     pop;
  logic                     do_flush;
  logic                     auto_flush_q;
  logic                     skew_now;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_fifo_ch #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .LW    (LW)
    ) u_fifo (
      .clk    (alg_clk),
      .rst    (alg_rst),
      .flush  (do_flush),
      .wr_en  (wr_acc[g]),
      .wr_data(in_data[lane_lo(g, DATA_W) +: DATA_W]),
      .rd_en  (pop),
      .rd_data(rd_word[lane_lo(g, DATA_W) +: DATA_W]),
      .level  (level[g]),
      .full   (full[g]),
      .empty  (empty[g])
    );
  end

  // Skew is judged on the levels the FIFOs will hold after this edge.
  always_comb begin
    logic [LW-1:0] nxt;
    logic [LW-1:0] lv_max;
    logic [LW-1:0] lv_min;
    nxt      = '0;
    lv_max   = '0;
    lv_min   = LW'(DEPTH);
    pop      = (&(~empty)) && (!out_valid || out_ready);
    do_flush = flush || auto_flush_q;
    wr_acc   = in_valid & (~full | {NUM_CH{pop}});
    drop     = in_valid & full & ~{NUM_CH{pop}};
    for (int i = 0; i < NUM_CH; i++) begin
      nxt = do_flush ? '0 :
            level[i] + LW'(wr_acc[i]) - LW'(pop);
      if (nxt > lv_max) lv_max = nxt;
      if (nxt < lv_min) lv_min = nxt;
    end
    skew_now = ((lv_max - lv_min) > LW'(SKEW_LIMIT));
  end

  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      overflow     <= '0;
      skew_err     <= 1'b0;
      word_count   <= '0;
      auto_flush_q <= 1'b0;
    end else begin
      auto_flush_q <= resync_en && !do_flush &&
                      ((|drop) || skew_now);
      overflow <= (clear_status ? '0 : overflow) | drop;
      skew_err <= (clear_status ? 1'b0 : skew_err) | skew_now;
      if (out_valid && out_ready && !do_flush)
        word_count <= word_count + CNT_W'(1);
      if (do_flush) begin
        out_valid <= 1'b0;
      end else if (pop) begin
        out_data  <= rd_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_multichannel_aligner.sv
// Directed bench for adc_multichannel_aligner, NUM_CH=2, DEPTH=16.
// Inputs change #1 after a rising edge; outputs sampled there too.
module tb_adc_multichannel_aligner;

  logic        clk = 1'b0;
  logic        alg_rst;
  logic [31:0] in_data;
  logic [1:0]  in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        resync_en;
  logic        clear_status;
  logic [1:0]  overflow;
  logic        skew_err;
  logic [31:0] word_count;

  int checks   = 0;
  int failures = 0;
  int nw;
  int first;
  logic [31:0] cnt0;

  adc_multichannel_aligner #(
    .NUM_CH    (2),
    .DATA_W    (16),
    .DEPTH     (16),
    .SKEW_LIMIT(8),
    .CNT_W     (32)
  ) dut (
    .alg_clk     (clk),
    .alg_rst     (alg_rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .resync_en   (resync_en),
    .clear_status(clear_status),
    .overflow    (overflow),
    .skew_err    (skew_err),
    .word_count  (word_count)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input int d0, input int d1);
    in_valid = v;
    in_data  = {16'(d1), 16'(d0)};
  endtask

  function automatic logic [31:0] pair(input int d0, input int d1);
    return {16'(d1), 16'(d0)};
  endfunction

  initial begin
    alg_rst      = 1'b1;
    in_data      = '0;
    in_valid     = '0;
    out_ready    = 1'b0;
    flush        = 1'b0;
    resync_en    = 1'b0;
    clear_status = 1'b0;
    step();
    step();
    alg_rst = 1'b0;
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", word_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_skew", skew_err, 0);

    // aligned writes, consumer always ready
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 'h1000 + k, 'h1000 + k);
      step();
      if (k > 0) begin
        chk("t1_vld", out_valid, 1);
        chk("t1_data", out_data, pair('h1000 + k - 1, 'h1000 + k - 1));
      end
    end
    drive(2'b00, 0, 0);
    step();
    chk("t1_last", out_data, pair('h1003, 'h1003));
    step();
    chk("t1_vld_end", out_valid, 0);
    chk("t1_cnt", word_count, 4);

    // channel 1 lags channel 0 by 3 cycles
    nw = 0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      drive({(c >= 3 && c < 9), (c < 6)}, 'h1000 + c, 'h2000 + c - 3);
      step();
      if (out_valid) begin
        if (nw == 0) first = c;
        chk("t2_lane0", out_data[15:0], 'h1000 + nw);
        chk("t2_lane1", out_data[31:16], 'h2000 + nw);
        nw++;
      end
    end
    drive(2'b00, 0, 0);
    chk("t2_first", first, 4);
    chk("t2_words", nw, 6);
    chk("t2_skew", skew_err, 0);
    chk("t2_cnt", word_count, 10);

    // consumer stalled: hold, fill, overflow, then drain
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, 'h1000 + c, 'h2000 + c);
      step();
      if (c == 10) chk("t3_hold_mid", out_data, pair('h1000, 'h2000));
    end
    drive(2'b00, 0, 0);
    chk("t3_vld", out_valid, 1);
    chk("t3_held", out_data, pair('h1000, 'h2000));
    chk("t3_ovf", overflow, 2'b11);
    out_ready = 1'b1;
    nw = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) begin
        chk("t3_drain", out_data, pair('h1000 + nw, 'h2000 + nw));
        nw++;
      end
      step();
    end
    chk("t3_nwords", nw, 17);
    chk("t3_cnt", word_count, 27);
    chk("t3_vld_end", out_valid, 0);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t3_clr", overflow, 0);

    // one-sided writes trip skew and auto resync
    resync_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      drive(2'b01, 'h1000 + c, 0);
      step();
      if (c == 7) chk("t4_skew_pre", skew_err, 0);
    end
    chk("t4_skew", skew_err, 1);
    chk("t4_novld", out_valid, 0);
    drive(2'b00, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 'h3000 + k, 'h4000 + k);
      step();
      if (k > 0) chk("t4_pair", out_data, pair('h3000 + k - 1, 'h4000 + k - 1));
    end
    drive(2'b00, 0, 0);
    step();
    chk("t4_pair_last", out_data, pair('h3002, 'h4002));
    step();
    chk("t4_skew_sticky", skew_err, 1);
    resync_en = 1'b0;

    // external flush with 5 buffered words and a held output
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(2'b11, 'h5000 + c, 'h6000 + c);
      step();
    end
    drive(2'b00, 0, 0);
    step();
    chk("t5_vld", out_valid, 1);
    chk("t5_data", out_data, pair('h5000, 'h6000));
    cnt0 = word_count;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_vld_flush", out_valid, 0);
    chk("t5_cnt", word_count, cnt0);
    chk("t5_skew", skew_err, 1);
    chk("t5_ovf", overflow, 0);
    out_ready = 1'b1;
    step();
    step();
    chk("t5_empty", out_valid, 0);
    drive(2'b11, 'h7000, 'h7100);
    step();
    drive(2'b00, 0, 0);
    step();
    chk("t5_fresh", out_data, pair('h7000, 'h7100));
    step();

    // reset mid-stream, then clear vs new overflow
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 'h8000 + c, 'h9000 + c);
      step();
    end
    chk("t6_pre_vld", out_valid, 1);
    alg_rst = 1'b1;
    step();
    alg_rst = 1'b0;
    drive(2'b00, 0, 0);
    chk("t6_vld", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_cnt", word_count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_skew", skew_err, 0);
    step();
    step();
    chk("t6_idle", out_valid, 0);
    for (int c = 0; c < 18; c++) begin
      drive(2'b11, 'ha000 + c, 'hb000 + c);
      clear_status = (c == 17);
      step();
    end
    clear_status = 1'b0;
    drive(2'b00, 0, 0);
    chk("t6_set_wins", overflow, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
